// File: rtl/uart_tx_frame_controller.sv
// UART transmit frame sequencer: start, 5-8 data bits LSB first,
// optional parity, 1 or 2 stop bits, with built-in baud tick generation.
module uart_tx_frame_controller #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  txValid,
    output logic                  txReady,
    input  logic [DATA_WIDTH-1:0] txData,
    input  logic [3:0]            cfgDataWidth,
    input  logic                  cfgParityEnable,
    input  logic                  cfgParityOdd,
    input  logic [1:0]            cfgStopBits,
    input  logic [4:0]            cfgOverSampling,
    input  logic [DIV_WIDTH-1:0]  cfgBaudDivisor,
    input  logic                  cfgParityErrInj,
    input  logic                  cfgFramingErrInj,
    input  logic                  cfgBreakInj,
    output logic                  tx,
    output logic [3:0]            txState,
    output logic                  frameDone,
    output logic                  busy
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_RESET = 4'd1;
    localparam logic [3:0] S_START = 4'd2;
    localparam logic [3:0] S_BIT0  = 4'd3;
    localparam logic [3:0] S_BIT7  = 4'd10;
    localparam logic [3:0] S_PAR   = 4'd11;
    localparam logic [3:0] S_STOP  = 4'd12;
    localparam logic [3:0] S_ISTOP = 4'd13;

    logic [DATA_WIDTH-1:0] data_q;
    logic [3:0]            w_q;
    logic                  pen_q;
    logic                  par_q;
    logic                  stop2_q;
    logic [4:0]            os_last_q;
    logic [DIV_WIDTH-1:0]  div_q;
    logic                  ferr_q;
    logic                  brk_q;
    logic [DIV_WIDTH-1:0]  tick_cnt;
    logic [4:0]            os_cnt;
    logic                  stop_cnt;

    logic       accept;
    logic       tick;
    logic       bit_end;
    logic       in_frame;
    logic [3:0] last_bit;
    logic [3:0] stop_state;
    logic [3:0] nstate;
    logic       stop_nxt;
    logic       done;
    logic       line;
    logic [2:0] bidx;
    logic [3:0] w_in;
    logic       par_in;

    assign accept     = txValid && txReady;
    assign tick       = (tick_cnt == div_q);
    assign bit_end    = tick && (os_cnt == os_last_q);
    assign in_frame   = (txState >= S_START) && (txState <= S_ISTOP);
    assign last_bit   = S_BIT0 + w_q - 4'd1;
    assign stop_state = ferr_q ? S_ISTOP : S_STOP;
    assign bidx       = 3'(nstate - S_BIT0);
    assign w_in       = (cfgDataWidth >= 4'd5 && cfgDataWidth <= 4'd8)
                        ? cfgDataWidth : 4'd8;

    // Parity of the active data bits, folded with odd and error injection
    always_comb begin
        par_in = cfgParityOdd ^ cfgParityErrInj;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (i < int'(w_in)) par_in = par_in ^ txData[i];
        end
    end

    // Next-state sequencing, advancing only on bit boundaries
    always_comb begin
        nstate   = txState;
        stop_nxt = stop_cnt;
        done     = 1'b0;
        unique case (1'b1)
            (txState == S_RESET): nstate = S_IDLE;
            (txState == S_IDLE): if (accept) nstate = S_START;
            (txState == S_START): if (bit_end) nstate = S_BIT0;
            (txState >= S_BIT0 && txState <= S_BIT7): begin
                if (bit_end) begin
                    if (txState == last_bit)
                        nstate = pen_q ? S_PAR : stop_state;
                    else
                        nstate = txState + 4'd1;
                end
            end
            (txState == S_PAR): if (bit_end) nstate = stop_state;
            (txState == S_STOP || txState == S_ISTOP): begin
                if (bit_end) begin
                    if (stop2_q && !stop_cnt) begin
                        stop_nxt = 1'b1;
                    end else begin
                        nstate = S_IDLE;
                        done   = 1'b1;
                    end
                end
            end
            default: nstate = S_IDLE;
        endcase
    end

    // Line level for the state being entered; break wins over everything
    always_comb begin
        line = 1'b1;
        unique case (1'b1)
            (nstate == S_START): line = 1'b0;
            (nstate >= S_BIT0 && nstate <= S_BIT7): line = data_q[bidx];
            (nstate == S_PAR): line = par_q;
            (nstate == S_ISTOP): line = 1'b0;
            default: line = 1'b1;
        endcase
        if (brk_q && nstate >= S_START && nstate <= S_ISTOP) line = 1'b0;
    end

    // Registered outputs and state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            txState   <= S_RESET;
            tx        <= 1'b1;
            txReady   <= 1'b0;
            frameDone <= 1'b0;
            busy      <= 1'b0;
        end else begin
            txState   <= nstate;
            tx        <= line;
            txReady   <= (nstate == S_IDLE);
            frameDone <= done;
            busy      <= !(nstate == S_IDLE || nstate == S_RESET);
        end
    end

    // Capture byte and frame configuration at handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q    <= '0;
            w_q       <= 4'd8;
            pen_q     <= 1'b0;
            par_q     <= 1'b0;
            stop2_q   <= 1'b0;
            os_last_q <= 5'd15;
            div_q     <= '0;
            ferr_q    <= 1'b0;
            brk_q     <= 1'b0;
        end else if (accept) begin
            data_q    <= txData;
            w_q       <= w_in;
            pen_q     <= cfgParityEnable;
            par_q     <= par_in;
            stop2_q   <= (cfgStopBits == 2'd2);
            os_last_q <= (cfgOverSampling == 5'd13) ? 5'd12 : 5'd15;
            div_q     <= cfgBaudDivisor;
            ferr_q    <= cfgFramingErrInj;
            brk_q     <= cfgBreakInj;
        end
    end

    // Baud tick, oversample and stop-bit counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
            os_cnt   <= '0;
            stop_cnt <= 1'b0;
        end else if (accept) begin
            tick_cnt <= '0;
            os_cnt   <= '0;
            stop_cnt <= 1'b0;
        end else if (in_frame) begin
            stop_cnt <= stop_nxt;
            if (tick) begin
                tick_cnt <= '0;
                os_cnt   <= (os_cnt == os_last_q) ? 5'd0 : os_cnt + 5'd1;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_controller.sv
// Directed self-checking bench for uart_tx_frame_controller.
// Each scenario task drives a frame and checks the logged line/state.
module tb_uart_tx_frame_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        txValid;
    logic        txReady;
    logic [7:0]  txData;
    logic [3:0]  cfgDataWidth;
    logic        cfgParityEnable;
    logic        cfgParityOdd;
    logic [1:0]  cfgStopBits;
    logic [4:0]  cfgOverSampling;
    logic [15:0] cfgBaudDivisor;
    logic        cfgParityErrInj;
    logic        cfgFramingErrInj;
    logic        cfgBreakInj;
    logic        tx;
    logic [3:0]  txState;
    logic        frameDone;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic       tx_log [0:1023];
    logic [3:0] st_log [0:1023];
    logic       fd_log [0:1023];

    uart_tx_frame_controller dut (
        .clk(clk),
        .reset(reset),
        .txValid(txValid),
        .txReady(txReady),
        .txData(txData),
        .cfgDataWidth(cfgDataWidth),
        .cfgParityEnable(cfgParityEnable),
        .cfgParityOdd(cfgParityOdd),
        .cfgStopBits(cfgStopBits),
        .cfgOverSampling(cfgOverSampling),
        .cfgBaudDivisor(cfgBaudDivisor),
        .cfgParityErrInj(cfgParityErrInj),
        .cfgFramingErrInj(cfgFramingErrInj),
        .cfgBreakInj(cfgBreakInj),
        .tx(tx),
        .txState(txState),
        .frameDone(frameDone),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int bit_err(int s, int n, logic v);
        int c = 0;
        for (int i = s; i < s + n; i++) if (tx_log[i] !== v) c++;
        return c;
    endfunction

    function automatic int st_err(int s, int n, logic [3:0] v);
        int c = 0;
        for (int i = s; i < s + n; i++) if (st_log[i] !== v) c++;
        return c;
    endfunction

    task automatic set_cfg(input logic [3:0] w, input logic pe,
                           input logic po, input logic [1:0] sb,
                           input logic [4:0] os, input logic [15:0] dv);
        cfgDataWidth     = w;
        cfgParityEnable  = pe;
        cfgParityOdd     = po;
        cfgStopBits      = sb;
        cfgOverSampling  = os;
        cfgBaudDivisor   = dv;
        cfgParityErrInj  = 1'b0;
        cfgFramingErrInj = 1'b0;
        cfgBreakInj      = 1'b0;
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tx_log[i] = tx;
            st_log[i] = txState;
            fd_log[i] = frameDone;
        end
    endtask

    // Raise txValid, wait for ready, hand over the byte at the next edge
    task automatic start_frame(input logic [7:0] d, input logic hold);
        bit ok = 1'b0;
        txData  = d;
        txValid = 1'b1;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            ok = (txReady === 1'b1);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL handshake_timeout: txReady=%b required 1", txReady);
        end
        @(posedge clk);
        #1;
        if (!hold) txValid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            ok = (txState === 4'd0);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL idle_timeout: txState=%0d required 0", txState);
        end
    endtask

    task automatic test_reset();
        set_cfg(4'd8, 1'b0, 1'b0, 2'd1, 5'd16, 16'd0);
        txData  = 8'hA5;
        txValid = 1'b1;
        reset   = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (txState !== 4'd1 || tx !== 1'b1 || txReady !== 1'b0 ||
            frameDone !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: st=%0d tx=%b rdy=%b fd=%b busy=%b required 1 1 0 0 0",
                     txState, tx, txReady, frameDone, busy);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (txState !== 4'd0 || txReady !== 1'b1) begin
            errors++;
            $display("FAIL reset_exit_idle: st=%0d rdy=%b required 0 1",
                     txState, txReady);
        end
        @(posedge clk);
        #1;
        txValid = 1'b0;
        checks++;
        if (txState !== 4'd2 || tx !== 1'b0 || txReady !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL first_handshake: st=%0d tx=%b rdy=%b busy=%b required 2 0 0 1",
                     txState, tx, txReady, busy);
        end
        wait_idle();
    endtask

    task automatic test_8n1();
        logic exp_bits [0:9] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        logic [3:0] exp_st [0:9] = '{2, 3, 4, 5, 6, 7, 8, 9, 10, 12};
        int bad = 0;
        set_cfg(4'd8, 1'b0, 1'b0, 2'd1, 5'd16, 16'd0);
        start_frame(8'hA5, 1'b0);
        capture(162);
        for (int k = 0; k < 10; k++) begin
            if (bit_err(k * 16, 16, exp_bits[k]) != 0) bad++;
            if (st_err(k * 16, 16, exp_st[k]) != 0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL 8n1_bits: bad_periods=%0d required 0", bad);
        end
        checks++;
        if (fd_log[159] !== 1'b0 || fd_log[160] !== 1'b1 || fd_log[161] !== 1'b0 ||
            st_log[160] !== 4'd0 || tx_log[160] !== 1'b1) begin
            errors++;
            $display("FAIL 8n1_done: fd=%b%b%b st=%0d tx=%b required 010 0 1",
                     fd_log[159], fd_log[160], fd_log[161], st_log[160], tx_log[160]);
        end
    endtask

    task automatic test_parity();
        set_cfg(4'd8, 1'b1, 1'b0, 2'd1, 5'd16, 16'd0);
        start_frame(8'hA5, 1'b0);
        capture(177);
        checks++;
        if (bit_err(144, 16, 1'b0) != 0 || st_err(144, 16, 4'd11) != 0) begin
            errors++;
            $display("FAIL 8e1_parity: tx=%b st=%0d required 0 11",
                     tx_log[150], st_log[150]);
        end
        checks++;
        if (bit_err(160, 16, 1'b1) != 0 || fd_log[176] !== 1'b1) begin
            errors++;
            $display("FAIL 8e1_stop: tx=%b fd=%b required 1 1",
                     tx_log[165], fd_log[176]);
        end
        set_cfg(4'd8, 1'b1, 1'b0, 2'd1, 5'd16, 16'd0);
        cfgParityErrInj = 1'b1;
        start_frame(8'hA5, 1'b0);
        capture(177);
        checks++;
        if (bit_err(144, 16, 1'b1) != 0 || st_err(144, 16, 4'd11) != 0) begin
            errors++;
            $display("FAIL 8e1_parity_inj: tx=%b st=%0d required 1 11",
                     tx_log[150], st_log[150]);
        end
    endtask

    task automatic test_7o2();
        logic exp_bits [0:6] = '{1, 0, 1, 0, 1, 0, 1};
        int bad = 0;
        set_cfg(4'd7, 1'b1, 1'b1, 2'd2, 5'd13, 16'd2);
        start_frame(8'hD5, 1'b0);
        set_cfg(4'd8, 1'b0, 1'b0, 2'd1, 5'd16, 16'd0);
        capture(431);
        checks++;
        if (bit_err(0, 39, 1'b0) != 0 || st_err(0, 39, 4'd2) != 0) begin
            errors++;
            $display("FAIL 7o2_start: tx=%b st=%0d required 0 2", tx_log[20], st_log[20]);
        end
        for (int k = 0; k < 7; k++) begin
            if (bit_err(39 * (k + 1), 39, exp_bits[k]) != 0) bad++;
            if (st_err(39 * (k + 1), 39, 4'(3 + k)) != 0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL 7o2_data: bad_periods=%0d required 0", bad);
        end
        checks++;
        if (bit_err(312, 39, 1'b1) != 0 || st_err(312, 39, 4'd11) != 0) begin
            errors++;
            $display("FAIL 7o2_parity: tx=%b st=%0d required 1 11",
                     tx_log[330], st_log[330]);
        end
        checks++;
        if (bit_err(351, 78, 1'b1) != 0 || st_err(351, 78, 4'd12) != 0) begin
            errors++;
            $display("FAIL 7o2_stop2: tx=%b st=%0d required 1 12",
                     tx_log[420], st_log[420]);
        end
        checks++;
        if (fd_log[428] !== 1'b0 || fd_log[429] !== 1'b1 || st_log[429] !== 4'd0) begin
            errors++;
            $display("FAIL 7o2_length: fd=%b%b st=%0d required 01 0",
                     fd_log[428], fd_log[429], st_log[429]);
        end
    endtask

    task automatic test_injection();
        set_cfg(4'd5, 1'b0, 1'b0, 2'd1, 5'd16, 16'd0);
        cfgFramingErrInj = 1'b1;
        start_frame(8'h15, 1'b0);
        capture(113);
        checks++;
        if (bit_err(16, 16, 1'b1) != 0 || bit_err(32, 16, 1'b0) != 0) begin
            errors++;
            $display("FAIL 5n1_data: b0=%b b1=%b required 1 0", tx_log[20], tx_log[40]);
        end
        checks++;
        if (bit_err(96, 16, 1'b0) != 0 || st_err(96, 16, 4'd13) != 0) begin
            errors++;
            $display("FAIL framing_stop: tx=%b st=%0d required 0 13",
                     tx_log[100], st_log[100]);
        end
        checks++;
        if (fd_log[112] !== 1'b1 || tx_log[112] !== 1'b1) begin
            errors++;
            $display("FAIL framing_done: fd=%b tx=%b required 1 1", fd_log[112], tx_log[112]);
        end
        set_cfg(4'd5, 1'b0, 1'b0, 2'd1, 5'd16, 16'd0);
        cfgBreakInj = 1'b1;
        start_frame(8'h15, 1'b0);
        capture(113);
        checks++;
        if (bit_err(0, 112, 1'b0) != 0) begin
            errors++;
            $display("FAIL break_line: high_cycles=%0d required 0", bit_err(0, 112, 1'b0));
        end
        checks++;
        if (st_err(16, 16, 4'd3) != 0 || st_err(96, 16, 4'd12) != 0 ||
            st_log[112] !== 4'd0 || tx_log[112] !== 1'b1) begin
            errors++;
            $display("FAIL break_states: st=%0d/%0d/%0d tx=%b required 3/12/0 1",
                     st_log[20], st_log[100], st_log[112], tx_log[112]);
        end
    endtask

    task automatic test_back_to_back();
        set_cfg(4'd5, 1'b0, 1'b0, 2'd1, 5'd16, 16'd0);
        start_frame(8'h0A, 1'b1);
        txData = 8'h15;
        capture(226);
        txValid = 1'b0;
        checks++;
        if (fd_log[112] !== 1'b1 || st_log[112] !== 4'd0 || tx_log[112] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap: fd=%b st=%0d tx=%b required 1 0 1",
                     fd_log[112], st_log[112], tx_log[112]);
        end
        checks++;
        if (st_log[113] !== 4'd2 || tx_log[113] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_start: st=%0d tx=%b required 2 0", st_log[113], tx_log[113]);
        end
        checks++;
        if (bit_err(16, 16, 1'b0) != 0 || bit_err(129, 16, 1'b1) != 0) begin
            errors++;
            $display("FAIL b2b_data: b0a=%b b0b=%b required 0 1", tx_log[20], tx_log[135]);
        end
        checks++;
        if (fd_log[225] !== 1'b1 || fd_log[224] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done: fd=%b%b required 01", fd_log[224], fd_log[225]);
        end
        wait_idle();
    endtask

    task automatic test_reset_mid_frame();
        set_cfg(4'd8, 1'b0, 1'b0, 2'd1, 5'd16, 16'd0);
        start_frame(8'hA5, 1'b0);
        capture(70);
        checks++;
        if (txState !== 4'd6 || tx !== 1'b0) begin
            errors++;
            $display("FAIL mid_bit3: st=%0d tx=%b required 6 0", txState, tx);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || txState !== 4'd1 || busy !== 1'b0 || txReady !== 1'b0) begin
            errors++;
            $display("FAIL async_abort: tx=%b st=%0d busy=%b rdy=%b required 1 1 0 0",
                     tx, txState, busy, txReady);
        end
        @(negedge clk);
        reset = 1'b1;
        wait_idle();
    endtask

    initial begin
        reset   = 1'b0;
        txValid = 1'b0;
        txData  = 8'h00;
        test_reset();
        test_8n1();
        test_parity();
        test_7o2();
        test_injection();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame_controller.md
Name: uart_tx_frame_controller

Overview:
Sequences one UART transmit frame per accepted byte: start bit, 5-8 data bits LSB first, optional parity, then 1 or 2 stop bits. Generates its own oversampled baud tick from a divisor, and reports progress using the UartTransmitterStateEnum encoding. Supports parity, framing and break error injection. Sits between the TX driver/BFM and the serial tx line.

Parameters:
DATA_WIDTH, 8, maximum data bits; txData width.
DIV_WIDTH, 16, width of the baud divisor.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
txValid  input  1  byte available
txReady  output  1  controller can accept a byte
txData  input  DATA_WIDTH  byte to send
cfgDataWidth  input  4  5..8; any other value is treated as 8
cfgParityEnable  input  1  1 = parity bit present
cfgParityOdd  input  1  0 = even, 1 = odd
cfgStopBits  input  2  2 = two stop bits; any other value = one
cfgOverSampling  input  5  13 or 16; any other value is treated as 16
cfgBaudDivisor  input  DIV_WIDTH  clk cycles per oversample tick, minus 1
cfgParityErrInj  input  1  invert the transmitted parity bit
cfgFramingErrInj  input  1  drive the stop bit(s) low
cfgBreakInj  input  1  hold tx low for the whole frame
tx  output  1  serial line, idle high
txState  output  4  enum encoding: IDLE=0, RESET=1, STARTBIT=2, BIT0..BIT7=3..10, PARITYBIT=11, STOPBIT=12, INVALIDSTOPBIT=13
frameDone  output  1  one-cycle pulse at frame end
busy  output  1  high in every state except IDLE and RESET

Behaviour:
- Reset values (asserted): txState=RESET, tx=1, txReady=0, frameDone=0, busy=0; all counters 0.
- At the first clk edge after reset deasserts, state goes to IDLE.
- Reset asserted mid-frame aborts the frame immediately and tx returns to 1 asynchronously.
- All outputs are registered.
- txReady=1 only while in IDLE.
- Handshake is txValid && txReady at a rising edge. On that edge:
  - txData and all cfg* inputs are latched.
  - Next cycle: state=STARTBIT, tx=0, txReady=0.
  - Config changes during a frame have no effect on that frame.
- Baud timing:
  - Tick counter counts 0..divisor and emits a tick when it equals the divisor. Divisor 0 gives a tick every cycle.
  - An oversample counter counts ticks 0..os-1. A bit boundary occurs on a tick with oversample counter = os-1.
  - Bit period is exactly os*(divisor+1) clk. Both counters are cleared on handshake.
- State sequence:
  - STARTBIT, then BIT0..BIT(w-1), then PARITYBIT if enabled, then STOPBIT, then IDLE.
  - With framing injection, INVALIDSTOPBIT replaces STOPBIT.
  - Each state lasts one bit period. The stop state lasts 2 bit periods when cfgStopBits=2.
- Data and parity:
  - BITn drives latched data[n]; bits at index w and above are ignored.
  - Parity = XOR of the w data bits, inverted if odd, then inverted again if cfgParityErrInj.
- Line override priority: break > framing > normal. Break forces tx=0 in all frame states; txState still sequences normally.
- Stop state exit: frameDone=1 for one cycle coincident with entering IDLE.
- Frame spacing: IDLE lasts at least one cycle, so back-to-back frames are separated by exactly 1 clk of idle-high when txValid is held.
- Frame length: (1 + w + P + S) bit periods.

Test Plan:
- Reset with txValid=1 → txState=RESET, tx=1, txReady=0. Deassert reset → IDLE next edge; handshake occurs on the following edge.
- 8N1, os=16, divisor=0, data 0xA5 → tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 clk. Frame 160 clk, then frameDone pulse.
- 8E1, data 0xA5 → parity bit 0 (four ones). Same frame with cfgParityErrInj=1 → parity bit 1, txState=PARITYBIT for 16 clk.
- 7O2, os=13, divisor=2, data 0xD5 → data bits 1010101 (bit7 ignored), parity 1. Bit period 39 clk, stop state 78 clk, total 11 bits = 429 clk.
- cfgFramingErrInj=1 with 5N1 → txState=INVALIDSTOPBIT, tx=0 for one bit period. cfgBreakInj=1 → tx=0 for the entire frame.
- txValid held with two bytes queued → second STARTBIT begins exactly 1 clk after frameDone. Reset asserted during BIT3 → tx=1 and txState=RESET immediately.
